// File: rtl/fft_agu.sv
// Address generator and sequencer for an in-place radix-2 DIT FFT over a two-port RAM.
// Define FFT_AGU_HOLD_EN to split each butterfly into a read cycle and a write-back cycle.
module fft_agu #(
    parameter int N = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [N-1:0]         add_a,
    output logic [N-1:0]         add_b,
    output logic [N-2:0]         twiddle_addr,
    output logic                 we,
    output logic [$clog2(N)-1:0] stage,
    output logic                 busy,
    output logic                 done
);

    localparam int SW = $clog2(N);
    localparam logic [N-2:0] ONES = '1;
    localparam logic [SW-1:0] LAST_S = SW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-2:0]  i;
    logic [SW-1:0] s;
    logic          adv;
    logic          last_bfly;
    logic          last_stage;
    logic [2*N-1:0] rot_a;
    logic [2*N-1:0] rot_b;

`ifdef FFT_AGU_HOLD_EN
    // ph = 0 is the read cycle, ph = 1 the write-back cycle of the same butterfly.
    logic ph;
    assign adv = ph;
`else
    assign adv = 1'b1;
`endif

    assign last_bfly  = (i == ONES);
    assign last_stage = (s == LAST_S);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            i     <= '0;
            s     <= '0;
`ifdef FFT_AGU_HOLD_EN
            ph    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    i <= '0;
                    s <= '0;
`ifdef FFT_AGU_HOLD_EN
                    ph <= 1'b0;
`endif
                    if (start) state <= RUN;
                end
                RUN: begin
`ifdef FFT_AGU_HOLD_EN
                    ph <= ~ph;
`endif
                    if (adv) begin
                        i <= i + 1'b1;
                        if (last_bfly) begin
                            if (last_stage) state <= DONE;
                            else            s <= s + 1'b1;
                        end
                    end
                end
                DONE: begin
                    i     <= '0;
                    s     <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Rotate-left within N bits: shift a doubled copy and keep the upper half.
    assign rot_a = {i, 1'b0, i, 1'b0} << s;
    assign rot_b = {i, 1'b1, i, 1'b1} << s;

    always_comb begin
        add_a        = '0;
        add_b        = '0;
        twiddle_addr = '0;
        we           = 1'b0;
        stage        = '0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            RUN: begin
                add_a        = rot_a[2*N-1:N];
                add_b        = rot_b[2*N-1:N];
                twiddle_addr = i & (ONES << (LAST_S - s));
                we           = adv;
                stage        = s;
                busy         = 1'b1;
            end
            DONE: begin
                stage = s;
                busy  = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/fft_agu.md
Name: fft_agu

Overview:
- Address generation unit and sequencer for the in-place radix-2 DIT FFT.
- Drives the shared read/write address pair and write enable of the two-port butterfly RAM directly upstream of it.
- Drives the twiddle ROM address for the butterfly datapath.
- Steps through every butterfly of every stage once per start request, then signals done to the top-level controller.

Parameters:
- N, 9, log2 of FFT points; RAM address width (512-point default).

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  begin a transform; sampled only in IDLE
- add_a  output  N  butterfly upper-leg address (RAM port A, read and write)
- add_b  output  N  butterfly lower-leg address (RAM port B, read and write)
- twiddle_addr  output  N-1  twiddle ROM index for the current butterfly
- we  output  1  RAM write enable for the current butterfly result
- stage  output  $clog2(N)  current stage number, 0..N-1
- busy  output  1  high from the first RUN cycle until DONE is exited
- done  output  1  one-cycle pulse at completion

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it overrides everything, including mid-transform.
- Reset values:
  - state = IDLE; all counters 0.
  - add_a = 0, add_b = 0, twiddle_addr = 0, stage = 0.
  - we = 0, busy = 0, done = 0.
- Internal counters:
  - bfly counter i, N-1 bits.
  - stage counter s, 0..N-1.
- FSM states:
  - IDLE: outputs hold reset values. start=1 -> RUN with i=0, s=0.
  - RUN: one butterfly per cycle with we=1 and busy=1.
    - Each cycle i increments.
    - When i = 2^(N-1)-1: i wraps to 0 and s increments.
    - When i = 2^(N-1)-1 and s = N-1: go to DONE.
  - DONE: one cycle. done=1, we=0, busy=1. Next state is IDLE unconditionally.
- Address generation (combinational from registered i and s):
  - ia = {i,1'b0} and ib = {i,1'b1}.
  - add_a = ia rotated left by s within N bits; add_b = ib rotated left by s.
  - twiddle_addr = i AND (all-ones << (N-1-s)), in N-1 bits.
- RAM timing:
  - RAM read is asynchronous and the butterfly datapath is combinational.
  - The result is written back in place to add_a/add_b on the same rising edge that advances i.
  - Consequently add_a and add_b never change while we=1 within a cycle.
- Latency and throughput:
  - First we=1 cycle is the cycle after start is sampled.
  - Total we=1 cycles per transform = N*2^(N-1) (2304 for N=9).
  - done asserts the cycle after the last write.
- start handling:
  - start during RUN or DONE is ignored, not queued.
  - start held high continuously begins a new transform on the first IDLE cycle after DONE.
- In RUN and DONE, stage equals s.
- Reset mid-RUN: the next cycle is IDLE with all outputs at reset values. RAM contents are then undefined with respect to the FFT.

Optional Feature:
- Macro: FFT_AGU_HOLD_EN.
- Defined:
  - Each butterfly occupies two cycles, with add_a, add_b and twiddle_addr held constant across both.
  - Cycle 1 has we=0 (read; the butterfly output register loads). Cycle 2 has we=1 (write back).
  - i advances only after the write cycle.
  - Total RUN cycles = 2*N*2^(N-1). done still follows the final write by one cycle.
- Undefined: single-cycle behaviour exactly as above.

Test Plan:
- N=3, reset held 2 cycles then released -> all outputs 0, state IDLE; start pulse -> next cycle we=1, add_a=0, add_b=1, twiddle_addr=0, stage=0, busy=1.
- N=3 stage 1 sequence -> (add_a,add_b,twiddle_addr) = (0,2,0), (4,6,0), (1,3,2), (5,7,2).
- N=3 stage 2 sequence -> (0,4,0), (1,5,1), (2,6,2), (3,7,3).
- N=3 full run -> exactly 12 we=1 cycles, done high for one cycle immediately after, busy low the cycle after done.
- N=3, start asserted in mid-RUN and during DONE -> no restart, count still 12; start held continuously -> second transform begins the cycle after the return to IDLE.
- N=9, reset asserted at butterfly 700 -> next cycle outputs zero and IDLE; a fresh start gives 2304 writes. With FFT_AGU_HOLD_EN, N=3 -> 24 RUN cycles with alternating we 0/1 and addresses stable across each pair.
